// File: rtl/div_issue_ctrl.sv
// Purpose: EX-stage initiator for the iterative divider; owns the HI/LO registers.
// Latency: issue-to-release 33 cycles (1 IDLE issue cycle + 32 BUSY cycles); results land at the complete edge.
// Backpressure: ex_div_stall holds EX while a division is in flight, or when a flushed op is still draining.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ex_valid/ex_op_*         EX instruction valid and decoded DIV/DIVU/MTHI/MTLO
//   ex_rs_value/ex_rt_value  dividend (or MTHI/MTLO data) and divisor
//   ex_flush/ex_advance      EX cancel and EX retire-at-edge
//   div_req/div_signed/div_x/div_y  request and operands to the divider, held stable while div_req=1
//   div_busy/div_complete/div_s/div_r  divider status and results
//   ex_div_stall             EX hold request
//   hi/lo                    architectural HI/LO values
module div_issue_ctrl #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] HILO_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_op_div,
  input  logic              ex_op_divu,
  input  logic              ex_op_mthi,
  input  logic              ex_op_mtlo,
  input  logic [DATA_W-1:0] ex_rs_value,
  input  logic [DATA_W-1:0] ex_rt_value,
  input  logic              ex_flush,
  input  logic              ex_advance,
  output logic              div_req,
  output logic              div_signed,
  output logic [DATA_W-1:0] div_x,
  output logic [DATA_W-1:0] div_y,
  input  logic              div_busy,
  input  logic              div_complete,
  input  logic [DATA_W-1:0] div_s,
  input  logic [DATA_W-1:0] div_r,
  output logic              ex_div_stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ABORT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;

  logic w_div_op;
  logic w_issue;
  logic w_hilo_op;
  logic w_unused_busy;

  // The divider's busy flag is informational only; completion is tracked via div_complete.
  assign w_unused_busy = div_busy;

  assign w_div_op  = ex_op_div | ex_op_divu;
  assign w_hilo_op = ex_op_mthi | ex_op_mtlo;
  assign w_issue   = ex_valid & w_div_op & ~ex_flush;

  always_comb begin
    ex_div_stall = 1'b0;
    case (r_state)
      S_IDLE:  ex_div_stall = w_issue;
      S_BUSY:  ex_div_stall = ~div_complete;
      // The aborted operation still occupies the divider and HI/LO; only
      // instructions that touch them must wait, everything else flows.
      S_ABORT: ex_div_stall = ex_valid & (w_div_op | w_hilo_op);
      default: ex_div_stall = 1'b0;
    endcase
  end

  // div_req is kept registered and equal to (state == BUSY || state == ABORT):
  // it is set on entry to BUSY and cleared on every exit to IDLE/DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      div_req    <= 1'b0;
      div_signed <= 1'b0;
      div_x      <= '0;
      div_y      <= '0;
      hi         <= HILO_RST_VAL;
      lo         <= HILO_RST_VAL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            div_x      <= ex_rs_value;
            div_y      <= ex_rt_value;
            div_signed <= ex_op_div;
            div_req    <= 1'b1;
            r_state    <= S_BUSY;
          end else if (ex_valid && !ex_flush) begin
            if (ex_op_mthi) hi <= ex_rs_value;
            if (ex_op_mtlo) lo <= ex_rs_value;
          end
        end
        S_BUSY: begin
          if (ex_flush) begin
            // A flush coinciding with completion drops the result and
            // releases the divider right away; otherwise drain in ABORT,
            // because releasing div_req early would freeze the divider.
            if (div_complete) begin
              div_req <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_ABORT;
            end
          end else if (div_complete) begin
            lo      <= div_s;
            hi      <= div_r;
            div_req <= 1'b0;
            r_state <= ex_advance ? S_IDLE : S_DONE;
          end
        end
        S_ABORT: begin
          if (div_complete) begin
            div_req <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          // DONE: the still-present DIV already committed; wait for it to
          // leave EX so it is not issued a second time.
          if (ex_advance || ex_flush) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
